imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/riscv_pkg.sv | 49 ++++
 rtl/imm_pack.sv | 42 ++++
 rtl/imm_encoder.sv | 167 ++++++++++++++++
 tb/tb_imm_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: XLEN and instruction-field constants, the immediate
// format encoding, and the combinational range/alignment check for immediates.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int INSTR_LSB = 7;

    // Immediate format selector; the 2-bit field decodes all four formats.
    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } immsrc_e;

    // Result of checking an immediate against its target format.
    typedef struct packed {
        logic range_err;
        logic align_err;
    } imm_chk_t;

    // A value fits a signed field when every bit above the field's top bit
    // equals that top bit.  B and J targets also drop bit 0, so it must be 0.
    function automatic imm_chk_t imm_check(input immsrc_e src, input logic [XLEN-1:0] imm);
        imm_chk_t res;
        res.range_err = 1'b0;
        res.align_err = 1'b0;
        case (src)
            IMM_I, IMM_S: begin
                res.range_err = !((&imm[XLEN-1:11]) || !(|imm[XLEN-1:11]));
                res.align_err = 1'b0;
            end
            IMM_B: begin
                res.range_err = !((&imm[XLEN-1:12]) || !(|imm[XLEN-1:12]));
                res.align_err = imm[0];
            end
            IMM_J: begin
                res.range_err = !((&imm[XLEN-1:20]) || !(|imm[XLEN-1:20]));
                res.align_err = imm[0];
            end
            default: begin
                res.range_err = 1'b0;
                res.align_err = 1'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Purely combinational immediate placement: scatters the low immediate bits into
// the instruction template according to the selected format.  Bits that the
// format does not own pass through from the template unchanged.
module imm_pack
    import riscv_pkg::*;
(
    input  logic [1:0]                 immsrc_i,
    input  logic [20:0]                imm_i,
    input  logic [XLEN-1:INSTR_LSB]    tmpl_i,
    output logic [XLEN-1:INSTR_LSB]    instr_o
);

    // Overlay the immediate fields onto the template for the selected format.
    always_comb begin
        instr_o = tmpl_i;
        case (immsrc_e'(immsrc_i))
            IMM_I: begin
                instr_o[31:20] = imm_i[11:0];
            end
            IMM_S: begin
                instr_o[31:25] = imm_i[11:5];
                instr_o[11:7]  = imm_i[4:0];
            end
            IMM_B: begin
                instr_o[31]    = imm_i[12];
                instr_o[7]     = imm_i[11];
                instr_o[30:25] = imm_i[10:5];
                instr_o[11:8]  = imm_i[4:1];
            end
            IMM_J: begin
                instr_o[31]    = imm_i[20];
                instr_o[19:12] = imm_i[19:12];
                instr_o[20]    = imm_i[11];
                instr_o[30:21] = imm_i[10:1];
            end
            default: begin
                instr_o = tmpl_i;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage elastic immediate encoder.  Stage 1 captures the request and
// evaluates the range/alignment checks; stage 2 holds the packed instruction
// and error flags until downstream takes them.  Erroneous results are still
// delivered (packed from the low bits) and counted in a saturating counter.
module imm_encoder
    import riscv_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 Immsrc,
    input  logic [XLEN-1:0]            imm,
    input  logic [XLEN-1:INSTR_LSB]    tmpl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:INSTR_LSB]    Instr,
    output logic                       range_err,
    output logic                       align_err,
    output logic [ERR_CNT_W-1:0]       err_cnt
);

    // Stage 1 state
    logic                       s1_valid_q,  s1_valid_d;
    logic [1:0]                 s1_immsrc_q, s1_immsrc_d;
    logic [XLEN-1:0]            s1_imm_q,    s1_imm_d;
    logic [XLEN-1:INSTR_LSB]    s1_tmpl_q,   s1_tmpl_d;

    // Stage 2 state (drives the outputs directly)
    logic                       s2_valid_q,  s2_valid_d;
    logic [XLEN-1:INSTR_LSB]    instr_q,     instr_d;
    logic                       range_err_q, range_err_d;
    logic                       align_err_q, align_err_d;

    logic [ERR_CNT_W-1:0]       err_cnt_q,   err_cnt_d;

    // Handshake / datapath helpers
    logic                       s1_en_s;
    logic                       s2_en_s;
    logic                       deliver_s;
    imm_chk_t                   s1_chk_s;
    logic [XLEN-1:INSTR_LSB]    pack_instr_s;

    // Stage enables: stage 2 may load when empty or draining; stage 1 may load
    // when empty or when its content moves on this edge.
    always_comb begin
        s2_en_s   = !s2_valid_q || out_ready;
        s1_en_s   = !s1_valid_q || s2_en_s;
        deliver_s = s2_valid_q && out_ready;
    end

    assign in_ready  = s1_en_s;
    assign out_valid = s2_valid_q;
    assign Instr     = instr_q;
    assign range_err = range_err_q;
    assign align_err = align_err_q;
    assign err_cnt   = err_cnt_q;

    // Error checks on the stage-1 registered request.
    always_comb begin
        s1_chk_s = imm_check(immsrc_e'(s1_immsrc_q), s1_imm_q);
    end

    imm_pack u_imm_pack (
        .immsrc_i (s1_immsrc_q),
        .imm_i    (s1_imm_q[20:0]),
        .tmpl_i   (s1_tmpl_q),
        .instr_o  (pack_instr_s)
    );

    // Stage 1 next state: capture a new request whenever the slot is free.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_immsrc_d = s1_immsrc_q;
        s1_imm_d    = s1_imm_q;
        s1_tmpl_d   = s1_tmpl_q;
        if (s1_en_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_immsrc_d = Immsrc;
                s1_imm_d    = imm;
                s1_tmpl_d   = tmpl;
            end else begin
                s1_immsrc_d = s1_immsrc_q;
                s1_imm_d    = s1_imm_q;
                s1_tmpl_d   = s1_tmpl_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: take the packed result from stage 1, hold while stalled.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        instr_d     = instr_q;
        range_err_d = range_err_q;
        align_err_d = align_err_q;
        if (s2_en_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d     = pack_instr_s;
                range_err_d = s1_chk_s.range_err;
                align_err_d = s1_chk_s.align_err;
            end else begin
                instr_d     = instr_q;
                range_err_d = range_err_q;
                align_err_d = align_err_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Error counter next state: count delivered results with any error, never wrap.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (deliver_s && (range_err_q || align_err_q) &&
            (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1'b1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_immsrc_q <= 2'b00;
            s1_imm_q    <= {XLEN{1'b0}};
            s1_tmpl_q   <= {(XLEN-INSTR_LSB){1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_immsrc_q <= s1_immsrc_d;
            s1_imm_q    <= s1_imm_d;
            s1_tmpl_q   <= s1_tmpl_d;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            instr_q     <= {(XLEN-INSTR_LSB){1'b0}};
            range_err_q <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            s2_valid_q  <= s2_valid_d;
            instr_q     <= instr_d;
            range_err_q <= range_err_d;
            align_err_q <= align_err_d;
        end
    end

    // Saturating error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= {ERR_CNT_W{1'b0}};
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder.  Two instances share all inputs: the
// default 8-bit counter and a 2-bit counter for saturation.  A behavioural
// model (arithmetic range test, field placement, sign-extend decode and an
// in-order queue) is checked against the DUT on every negative clock edge.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  Immsrc = 2'b00;
    logic [31:0] imm = 32'h0;
    logic [31:7] tmpl = 25'h0;

    logic        in_ready, out_valid, range_err, align_err;
    logic [31:7] Instr;
    logic [7:0]  err_cnt;
    logic        s_in_ready, s_out_valid, s_range_err, s_align_err;
    logic [31:7] s_Instr;
    logic [1:0]  s_err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    imm_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .Immsrc(Immsrc), .imm(imm), .tmpl(tmpl), .out_valid(out_valid),
        .out_ready(out_ready), .Instr(Instr), .range_err(range_err),
        .align_err(align_err), .err_cnt(err_cnt)
    );

    imm_encoder #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .Immsrc(Immsrc), .imm(imm), .tmpl(tmpl), .out_valid(s_out_valid),
        .out_ready(out_ready), .Instr(s_Instr), .range_err(s_range_err),
        .align_err(s_align_err), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_range(input int src, input int v);
        longint lim;
        case (src)
            0, 1:    lim = 64'sd2048;
            2:       lim = 64'sd4096;
            default: lim = 64'sd1048576;
        endcase
        return (longint'(v) < -lim) || (longint'(v) >= lim);
    endfunction

    function automatic bit m_align(input int src, input int v);
        return (src >= 2) && (v % 2 != 0);
    endfunction

    function automatic logic [31:0] m_encode(input int src, input logic [31:0] v, input logic [31:0] t);
        logic [31:0] w;
        w = t;
        w[6:0] = 7'h0;
        case (src)
            0: w[31:20] = v[11:0];
            1: begin w[31:25] = v[11:5]; w[11:7] = v[4:0]; end
            2: begin w[31] = v[12]; w[7] = v[11]; w[30:25] = v[10:5]; w[11:8] = v[4:1]; end
            default: begin w[31] = v[20]; w[19:12] = v[19:12]; w[20] = v[11]; w[30:21] = v[10:1]; end
        endcase
        return w;
    endfunction

    function automatic logic [31:0] m_decode(input int src, input logic [31:0] w);
        case (src)
            0: return {{20{w[31]}}, w[31:20]};
            1: return {{20{w[31]}}, w[31:25], w[11:7]};
            2: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        endcase
    endfunction

    typedef struct {
        int          src;
        logic [31:0] imm;
        logic [31:0] word;
        bit          rerr;
        bit          aerr;
    } exp_t;

    exp_t q[$];
    int   m_err8 = 0;
    int   m_err2 = 0;

    // Compare process: check outputs against the model, then account for the
    // transfers that the coming rising edge will perform.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_err8 = 0;
            m_err2 = 0;
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_in_ready", in_ready, 1'b1);
            chk("rst_err_cnt", err_cnt, 8'd0);
            chk("rst_instr", Instr, 25'h0);
            chk("rst_flags", {range_err, align_err}, 2'b00);
            chk("rst_sat_err_cnt", s_err_cnt, 2'd0);
        end else begin
            chk("in_ready", in_ready, (q.size() < 2) || out_ready);
            chk("sat_in_ready", s_in_ready, (q.size() < 2) || out_ready);
            if (q.size() == 0) chk("out_valid_empty", out_valid, 1'b0);
            if (q.size() == 2) chk("out_valid_full", out_valid, 1'b1);
            chk("sat_out_valid", s_out_valid, out_valid);
            chk("err_cnt", err_cnt, m_err8);
            chk("sat_err_cnt", s_err_cnt, m_err2);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1'b1, 1'b0);
                end else begin
                    chk("instr", {Instr, 7'h0}, q[0].word);
                    chk("sat_instr", {s_Instr, 7'h0}, q[0].word);
                    chk("range_err", range_err, q[0].rerr);
                    chk("align_err", align_err, q[0].aerr);
                    chk("sat_flags", {s_range_err, s_align_err}, {q[0].rerr, q[0].aerr});
                    if (!q[0].rerr && !q[0].aerr)
                        chk("roundtrip", m_decode(q[0].src, {Instr, 7'h0}), q[0].imm);
                end
            end
            if (out_valid && out_ready && q.size() > 0) begin
                if (q[0].rerr || q[0].aerr) begin
                    if (m_err8 < 255) m_err8++;
                    if (m_err2 < 3) m_err2++;
                end
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.src  = int'(Immsrc);
                e.imm  = imm;
                e.word = m_encode(int'(Immsrc), imm, {tmpl, 7'h0});
                e.rerr = m_range(int'(Immsrc), int'(imm));
                e.aerr = m_align(int'(Immsrc), int'(imm));
                q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Present one request and hold it until accepted.  A stalled attempt
    // re-enables out_ready so a randomly stalled stream cannot deadlock.
    task automatic send(input logic [1:0] src, input logic [31:0] v, input logic [31:0] t);
        bit acc;
        acc = 1'b0;
        Immsrc = src; imm = v; tmpl = t[31:7]; in_valid = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) out_ready = 1'b1;
        end
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] w, input bit re, input bit ae);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk({name, "_seen"}, seen, 1'b1);
        chk({name, "_instr"}, {Instr, 7'h0}, w);
        chk({name, "_flags"}, {range_err, align_err}, {re, ae});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = (q.size() == 0) && !out_valid;
        end
        chk("drain_timeout", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    // Boundary vectors: {src, value}
    int bnd_src [12] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 3, 3, 3};
    int bnd_val [12] = '{2047, -2048, 2048, -2049, 2047, -2049, 4094, -4096, 4096,
                         1048574, -1048576, 1048576};
    int          bp_src [4] = '{1, 0, 2, 3};
    logic [31:0] bp_imm [4] = '{32'hFFFFF800, 32'h0000007B, 32'hFFFFF00E, 32'h000FFFFE};
    logic [31:0] bp_tpl [4] = '{32'h00001234, 32'h000ABC80, 32'h00055500, 32'h00000F80};

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:7] held;
        int          idx;
        bit          acc;
        int          v;
        int          src;

        // model pins
        chk("model_enc_I", m_encode(0, 32'hFFFFFFFF, 32'h0), 32'hFFF00000);
        chk("model_enc_B", m_encode(2, 32'h00000800, 32'h0), 32'h00000080);
        chk("model_enc_J", m_encode(3, 32'h00100000, 32'h0), 32'h80000000);
        chk("model_range_J", m_range(3, 32'h00100000), 1'b1);
        chk("model_range_B", m_range(2, 3), 1'b0);
        chk("model_align_B", m_align(2, 3), 1'b1);
        chk("model_dec_B", m_decode(2, 32'h00000080), 32'h00000800);

        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // latency and basic I encoding
        Immsrc = 2'b00; imm = 32'hFFFFFFFF; tmpl = 25'h0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_one_cycle", out_valid, 1'b0);
        @(negedge clk);
        chk("lat_two_cycles", out_valid, 1'b1);
        chk("basic_I_instr", {Instr, 7'h0}, 32'hFFF00000);
        chk("basic_I_flags", {range_err, align_err}, 2'b00);
        @(posedge clk);
        #1;

        send(2'b10, 32'h00000800, 32'h0);
        expect_out("basic_B", 32'h00000080, 1'b0, 1'b0);
        send(2'b11, 32'h00100000, 32'h0);
        expect_out("range_J", 32'h80000000, 1'b1, 1'b0);
        send(2'b10, 32'h00000003, 32'h0);
        expect_out("align_B", 32'h00000100, 1'b0, 1'b1);
        @(negedge clk);
        chk("err_cnt_two", err_cnt, 8'd2);

        // saturation: six more erroneous transfers
        @(posedge clk);
        #1;
        repeat (6) send(2'b10, 32'h00000001, 32'h0);
        drain();
        @(negedge clk);
        chk("err_cnt_eight", err_cnt, 8'd8);
        chk("sat_err_cnt_three", s_err_cnt, 2'd3);
        @(posedge clk);
        #1;

        // backpressure: out_ready low for 5 cycles while streaming 4 requests
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            Immsrc = bp_src[idx][1:0]; imm = bp_imm[idx]; tmpl = bp_tpl[idx][31:7];
            in_valid = 1'b1;
            if (c == 5) out_ready = 1'b1;
            @(negedge clk);
            if (c == 2) held = Instr;
            if (c == 3) chk("bp_in_ready_low", in_ready, 1'b0);
            if (c == 4) chk("bp_hold", Instr, held);
            if (c == 5) chk("bp_release_ready", in_ready, 1'b1);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", idx, 4);
        drain();

        // boundary values
        for (int i = 0; i < 12; i++) send(bnd_src[i][1:0], bnd_val[i], 32'hA5A5A580);
        drain();

        // reset with two requests in flight
        out_ready = 1'b0;
        send(2'b00, 32'h00000005, 32'h00000F80);
        send(2'b01, 32'hFFFFFFF9, 32'h00003000);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_err_cnt", err_cnt, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_output", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // random in-range round-trip with random backpressure
        for (int n = 0; n < 10000; n++) begin
            src = int'($urandom_range(0, 3));
            case (src)
                0, 1:    v = int'($urandom_range(0, 4095)) - 2048;
                2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
                default: v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            send(src[1:0], v, $urandom());
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
